// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch/decode/update next-PC controller.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        UPDATE  = 3'd3,
        HALTED  = 3'd4
    } state_e;

    localparam int unsigned DEFAULT_ADDR_W   = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'd0;
    localparam int unsigned PC_INC           = 1;

    function automatic logic redirect_taken(input logic is_branch,
                                            input logic branch_cond,
                                            input logic is_jal);
        return is_jal | (is_branch & branch_cond);
    endfunction

endpackage

// File: rtl/pc_target_adder.sv
// Branch/jump target: PC plus the byte immediate converted to words (arithmetic shift).
module pc_target_adder #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] imm,
    output logic [ADDR_W-1:0] target
);

    logic signed [ADDR_W-1:0] word_off;

    // imm[1:0] falls off the shift; the sum wraps modulo 2^ADDR_W.
    assign word_off = $signed(imm) >>> 2;
    assign target   = pc + $unsigned(word_off);

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle next-PC controller: FETCH -> DECODE -> UPDATE loop with stall and halt.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned        ADDR_W   = DEFAULT_ADDR_W,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter int unsigned        CNT_W    = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    output logic              instr_valid,
    input  logic              branch_valid,
    input  logic              is_branch,
    input  logic              branch_cond,
    input  logic              is_jal,
    input  logic [ADDR_W-1:0] imm,
    input  logic              stall,
    input  logic              halt,
    output logic [ADDR_W-1:0] pc,
    output logic              redirect,
    output logic              busy,
    output logic [CNT_W-1:0]  taken_count,
    output state_e            state_dbg
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                first_q, first_d;
    logic                dec_branch_q, dec_branch_d;
    logic                dec_cond_q, dec_cond_d;
    logic                dec_jal_q, dec_jal_d;
    logic [ADDR_W-1:0]   dec_imm_q, dec_imm_d;
    logic [ADDR_W-1:0]   target;

    pc_target_adder #(.ADDR_W(ADDR_W)) u_target_adder (
        .pc     (pc_q),
        .imm    (dec_imm_q),
        .target (target)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            cnt_q        <= '0;
            first_q      <= 1'b0;
            dec_branch_q <= 1'b0;
            dec_cond_q   <= 1'b0;
            dec_jal_q    <= 1'b0;
            dec_imm_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            cnt_q        <= cnt_d;
            first_q      <= first_d;
            dec_branch_q <= dec_branch_d;
            dec_cond_q   <= dec_cond_d;
            dec_jal_q    <= dec_jal_d;
            dec_imm_q    <= dec_imm_d;
        end
    end

    // Fetch handshake: imem_req is held high for the whole FETCH state and the
    // transfer completes on the first cycle in which imem_req and imem_ack are both high.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        cnt_d        = cnt_q;
        first_d      = 1'b0;
        dec_branch_d = dec_branch_q;
        dec_cond_d   = dec_cond_q;
        dec_jal_d    = dec_jal_q;
        dec_imm_d    = dec_imm_q;
        imem_req     = 1'b0;
        instr_valid  = 1'b0;
        redirect     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_d = DECODE;
                    first_d = 1'b1;
                end
            end
            DECODE: begin
                instr_valid = first_q;
                if (!stall && branch_valid) begin
                    dec_branch_d = is_branch;
                    dec_cond_d   = branch_cond;
                    dec_jal_d    = is_jal;
                    dec_imm_d    = imm;
                    state_d      = UPDATE;
                end
            end
            UPDATE: begin
                if (!stall) begin
                    if (redirect_taken(dec_branch_q, dec_cond_q, dec_jal_q)) begin
                        pc_d     = target;
                        redirect = 1'b1;
                        // Saturate rather than wrap so a long run never reads as few redirects.
                        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                    end else begin
                        pc_d = pc_q + ADDR_W'(PC_INC);
                    end
                    state_d = halt ? HALTED : FETCH;
                end
            end
            HALTED: begin
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign taken_count = cnt_q;
    assign busy        = (state_q != IDLE) && (state_q != HALTED);
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer against a word-PC reference model.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    localparam int unsigned CNT_W = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        instr_valid;
    logic        branch_valid;
    logic        is_branch;
    logic        branch_cond;
    logic        is_jal;
    logic [31:0] imm;
    logic        stall;
    logic        halt;
    logic [31:0] pc;
    logic        redirect;
    logic        busy;
    logic [CNT_W-1:0] taken_count;
    state_e      state_dbg;

    int total  = 0;
    int passed = 0;
    logic [31:0]      exp_pc;
    logic [CNT_W-1:0] exp_cnt;

    pc_sequencer #(.ADDR_W(32), .RESET_PC(32'd0), .CNT_W(CNT_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .instr_valid  (instr_valid),
        .branch_valid (branch_valid),
        .is_branch    (is_branch),
        .branch_cond  (branch_cond),
        .is_jal       (is_jal),
        .imm          (imm),
        .stall        (stall),
        .halt         (halt),
        .pc           (pc),
        .redirect     (redirect),
        .busy         (busy),
        .taken_count  (taken_count),
        .state_dbg    (state_dbg)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called one tick after the edge that entered FETCH; runs one full instruction.
    task automatic run_instr(input logic br, input logic cond, input logic jal,
                             input logic [31:0] im, input int ack_dly, input int bv_dly,
                             input int stall_n, input logic hlt);
        logic tk;
        int   off;
        tk = jal | (br & cond);
        for (int i = 0; i < ack_dly; i++) begin
            imem_ack = 1'b0;
            #1;
            check("fetch_req_wait", imem_req, 1'b1);
            check("fetch_addr_wait", imem_addr, exp_pc);
            step();
        end
        imem_ack = 1'b1;
        #1;
        check("fetch_req", imem_req, 1'b1);
        check("fetch_addr", imem_addr, exp_pc);
        step();
        imem_ack = 1'b0;
        #1;
        check("decode_state", state_dbg, DECODE);
        check("instr_valid_first", instr_valid, 1'b1);
        check("decode_req_low", imem_req, 1'b0);
        for (int k = 0; k < bv_dly; k++) begin
            branch_valid = 1'b0;
            step();
            check("instr_valid_once", instr_valid, 1'b0);
        end
        branch_valid = 1'b1;
        is_branch    = br;
        branch_cond  = cond;
        is_jal       = jal;
        imm          = im;
        step();
        branch_valid = 1'b0;
        is_branch    = 1'($urandom_range(0, 1));
        branch_cond  = 1'($urandom_range(0, 1));
        is_jal       = 1'($urandom_range(0, 1));
        imm          = $urandom;
        #1;
        check("update_state", state_dbg, UPDATE);
        check("update_iv_low", instr_valid, 1'b0);
        for (int s = 0; s < stall_n; s++) begin
            stall = 1'b1;
            #1;
            check("stall_redirect", redirect, 1'b0);
            check("stall_pc", pc, exp_pc);
            step();
        end
        stall = 1'b0;
        halt  = hlt;
        #1;
        check("redirect", redirect, tk);
        step();
        halt = 1'b0;
        if (tk) begin
            off    = int'(im) >>> 2;
            exp_pc = exp_pc + 32'(off);
            if (exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
        end else begin
            exp_pc = exp_pc + 32'd1;
        end
        #1;
        check("pc_after", pc, exp_pc);
        check("taken_count", taken_count, exp_cnt);
        check("redirect_pulse_end", redirect, 1'b0);
        check("next_state", state_dbg, hlt ? HALTED : FETCH);
        check("busy_after", busy, !hlt);
    endtask

    initial begin
        logic [31:0] d;
        reset = 1'b0; start = 1'b0; imem_ack = 1'b0; branch_valid = 1'b0;
        is_branch = 1'b0; branch_cond = 1'b0; is_jal = 1'b0; imm = '0;
        stall = 1'b0; halt = 1'b0;
        exp_pc = 32'd0; exp_cnt = '0;
        #2;
        check("rst_state", state_dbg, IDLE);
        check("rst_pc", pc, 32'd0);
        check("rst_req", imem_req, 1'b0);
        check("rst_iv", instr_valid, 1'b0);
        check("rst_redirect", redirect, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_cnt", taken_count, '0);
        @(negedge clock);
        reset = 1'b1;
        step();
        step();
        check("idle_hold", state_dbg, IDLE);
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_fetch", state_dbg, FETCH);
        check("start_busy", busy, 1'b1);

        // Sequential fetches 0..3
        for (int n = 0; n < 4; n++) run_instr(0, 0, 0, 32'd0, 0, 0, 0, 0);
        run_instr(0, 0, 1, 32'd4, 0, 0, 0, 0);            // 4 -> 5
        run_instr(1, 1, 0, 32'd8, 0, 0, 0, 0);            // 5 -> 7
        run_instr(1, 0, 0, 32'd8, 0, 0, 0, 0);            // 7 -> 8 not taken
        run_instr(0, 0, 1, 32'd8, 0, 0, 0, 0);            // 8 -> 10
        run_instr(0, 0, 1, 32'hFFFF_FFF4, 0, 0, 0, 0);    // 10 -> 7
        run_instr(0, 0, 1, 32'd12, 0, 0, 0, 0);           // 7 -> 10
        run_instr(0, 0, 1, 32'd6, 0, 0, 0, 0);            // 10 -> 11
        run_instr(0, 0, 1, 32'hFFFF_FFD4, 0, 0, 0, 0);    // 11 -> 0
        run_instr(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);    // 0 -> FFFFFFFF
        check("wrap_down", pc, 32'hFFFF_FFFF);
        run_instr(0, 0, 0, 32'd0, 0, 0, 0, 0);            // wrap to 0
        check("wrap_up", pc, 32'd0);
        run_instr(0, 0, 0, 32'd0, 4, 0, 0, 0);            // delayed ack
        run_instr(1, 1, 0, 32'd20, 0, 1, 3, 0);           // stalled update

        for (int r = 0; r < 12; r++) begin
            run_instr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 32'($urandom_range(0, 800)) - 32'd400,
                      $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2), 0);
        end

        d = 32'd3 - exp_pc;
        run_instr(0, 0, 1, d << 2, 0, 0, 0, 0);
        check("at_three", pc, 32'd3);
        run_instr(0, 0, 0, 32'd0, 0, 0, 0, 1);            // halt, not taken
        check("halt_pc", pc, 32'd4);
        start = 1'b1;
        for (int h = 0; h < 3; h++) begin
            step();
            check("halted_state", state_dbg, HALTED);
            check("halted_pc", pc, 32'd4);
            check("halted_req", imem_req, 1'b0);
            check("halted_iv", instr_valid, 1'b0);
        end
        start = 1'b0;

        reset = 1'b0;
        exp_pc = 32'd0; exp_cnt = '0;
        #1;
        check("rst2_state", state_dbg, IDLE);
        check("rst2_pc", pc, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        run_instr(0, 0, 1, 32'd8, 0, 0, 0, 0);            // 0 -> 2
        imem_ack = 1'b0;
        step();
        check("pre_abort_req", imem_req, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("abort_state", state_dbg, IDLE);
        check("abort_pc", pc, 32'd0);
        check("abort_req", imem_req, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_cnt", taken_count, '0);
        check("abort_iv", instr_valid, 1'b0);
        check("abort_redirect", redirect, 1'b0);
        @(negedge clock);
        reset = 1'b1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
